// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, divisor type and oversample counter width helper.
package uart_pkg;
    localparam int DVSR_W_DEF     = 16;
    localparam int FRAC_W_DEF     = 4;
    localparam int OVERSAMPLE_DEF = 16;
    typedef logic [DVSR_W_DEF-1:0] dvsr_t;
    function automatic int os_cnt_w(input int oversample);
        return (oversample > 1) ? $clog2(oversample) : 1;
    endfunction
endpackage

// File: rtl/baud_frac_acc.sv
// baud_frac_acc: fractional divisor accumulator; carry_o requests one extra cycle in the period being loaded.
module baud_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              step_i,
    input  logic              clear_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              carry_o
);
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W:0]   sum;
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, frac_i};
        carry_o = sum[FRAC_W];
        acc_d   = clear_i ? '0 : step_i ? sum[FRAC_W-1:0] : acc_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) acc_q <= '0;
        else         acc_q <= acc_d;
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: UART baud tick generator (oversample, mid-bit and bit ticks).
// Define BAUD_TICK_GEN_FRAC_EN to add the fractional divisor accumulator.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int DVSR_W     = DVSR_W_DEF,
    parameter int FRAC_W     = FRAC_W_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              restart_i,
    input  logic [DVSR_W-1:0] dvsr_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              os_tick_o,
    output logic              mid_tick_o,
    output logic              bit_tick_o
);
    localparam int OS_W = os_cnt_w(OVERSAMPLE);
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic [DVSR_W:0]   term_q, term_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic              carry, os_tick;
`ifdef BAUD_TICK_GEN_FRAC_EN
    baud_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .step_i  (os_tick),
        .clear_i (restart_i),
        .frac_i  (frac_i),
        .carry_o (carry)
    );
`else
    logic unused_frac;
    assign unused_frac = ^frac_i;
    assign carry       = 1'b0;
`endif
    // rst_ni gates the tick: reset state has cnt_q == term_q, which would otherwise fire.
    always_comb begin
        os_tick    = rst_ni & en_i & ~restart_i & ({1'b0, cnt_q} == term_q);
        os_tick_o  = os_tick;
        mid_tick_o = os_tick & (os_cnt_q == OS_W'(OVERSAMPLE/2-1));
        bit_tick_o = os_tick & (os_cnt_q == OS_W'(OVERSAMPLE-1));
        cnt_d      = (restart_i | os_tick) ? '0 : en_i ? cnt_q + DVSR_W'(1) : cnt_q;
        os_cnt_d   = restart_i ? '0 : os_tick ? os_cnt_q + OS_W'(1) : os_cnt_q;
        term_d     = restart_i ? {1'b0, dvsr_i}
                   : os_tick   ? {1'b0, dvsr_i} + {{DVSR_W{1'b0}}, carry} : term_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            cnt_q    <= '0;
            term_q   <= '0;
            os_cnt_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            term_q   <= term_d;
            os_cnt_q <= os_cnt_d;
        end
endmodule
